// File: rtl/mem_bus_pkg.sv
// Shared definitions for the multiplexed external memory bus sequencer.
// Holds the FSM encoding and default watchdog sizing.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned DefDataWidth     = 32;
  localparam int unsigned DefAddrWidth     = 24;
  localparam int unsigned DefTimeoutCycles = 16;
  localparam int unsigned DefTimeoutWidth  = 5;

  // Address phase drives the core address zero-extended onto the AD lines.
  function automatic logic [DefDataWidth-1:0] zext_addr(input logic [DefAddrWidth-1:0] a);
    return {{(DefDataWidth-DefAddrWidth){1'b0}}, a};
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Data-phase wait counter: synchronous clear, count enable, terminal-count flag at TimeoutCycles-1.
// Latency: tc reflects the registered count; no backpressure, it saturates at terminal count.
module bus_wait_timer
  import mem_bus_pkg::*;
#(
  parameter int unsigned TimeoutCycles = DefTimeoutCycles,
  parameter int unsigned TimeoutWidth  = DefTimeoutWidth
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TimeoutWidth-1:0] count;

  assign tc = (count == TimeoutWidth'(TimeoutCycles - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_seq.sv
// Multiplexed AD-bus cycle sequencer: address phase, data phase with wait states, done/ack.
// Latency req->ack is 3 cycles plus wait states; req is ignored while busy, watchdog aborts with err.
module mem_bus_seq
  import mem_bus_pkg::*;
#(
  parameter int unsigned DataWidth     = DefDataWidth,
  parameter int unsigned AddrWidth     = DefAddrWidth,
  parameter int unsigned TimeoutCycles = DefTimeoutCycles,
  parameter int unsigned TimeoutWidth  = DefTimeoutWidth
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 we,
  input  logic [AddrWidth-1:0] addr,
  input  logic [DataWidth-1:0] wdata,
  output logic                 busy,
  output logic                 ack,
  output logic                 err,
  output logic [DataWidth-1:0] rdata,
  output logic                 addr_sel_n,
  output logic [DataWidth-1:0] bus_ad_out,
  output logic                 bus_ad_oe,
  input  logic [DataWidth-1:0] bus_ad_in,
  output logic                 bus_ale,
  output logic                 bus_rd_n,
  output logic                 bus_wr_n,
  input  logic                 bus_ready
);

  state_t                 state;
  logic                   cap_we;
  logic [DataWidth-1:0]   cap_wdata;
  logic                   wait_tc;

  bus_wait_timer #(
    .TimeoutCycles (TimeoutCycles),
    .TimeoutWidth  (TimeoutWidth)
  ) u_wait_timer (
    .clock (clock),
    .reset (reset),
    .clr   (state == ST_ADDR),
    .en    (state == ST_DATA),
    .tc    (wait_tc)
  );

  // Outputs are loaded on the edge entering each state so they are valid for its whole cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cap_we     <= 1'b0;
      cap_wdata  <= '0;
      busy       <= 1'b0;
      ack        <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
      addr_sel_n <= 1'b0;
      bus_ad_out <= '0;
      bus_ad_oe  <= 1'b0;
      bus_ale    <= 1'b0;
      bus_rd_n   <= 1'b1;
      bus_wr_n   <= 1'b1;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            state      <= ST_ADDR;
            cap_we     <= we;
            cap_wdata  <= wdata;
            busy       <= 1'b1;
            bus_ale    <= 1'b1;
            bus_ad_oe  <= 1'b1;
            bus_ad_out <= {{(DataWidth-AddrWidth){1'b0}}, addr};
            addr_sel_n <= 1'b0;
          end
        end
        ST_ADDR: begin
          state      <= ST_DATA;
          bus_ale    <= 1'b0;
          addr_sel_n <= 1'b1;
          if (cap_we) begin
            bus_ad_oe  <= 1'b1;
            bus_ad_out <= cap_wdata;
            bus_wr_n   <= 1'b0;
          end else begin
            bus_ad_oe  <= 1'b0;
            bus_rd_n   <= 1'b0;
          end
        end
        ST_DATA: begin
          // Ready on the terminal-count cycle still counts as a successful transfer.
          if (bus_ready || wait_tc) begin
            state     <= ST_DONE;
            ack       <= 1'b1;
            err       <= !bus_ready;
            bus_rd_n  <= 1'b1;
            bus_wr_n  <= 1'b1;
            bus_ad_oe <= 1'b0;
            if (bus_ready && !cap_we) begin
              rdata <= bus_ad_in;
            end
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          addr_sel_n <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_strobe_excl: assert property (@(posedge clock) disable iff (!reset)
    !(!bus_rd_n && !bus_wr_n));
  a_ale_excl: assert property (@(posedge clock) disable iff (!reset)
    !(bus_ale && (!bus_rd_n || !bus_wr_n)));

endmodule

// File: tb/tb_mem_bus_seq.sv
// Directed bench for mem_bus_seq: stimulus pushes expected completions, a negedge monitor checks them.
module tb_mem_bus_seq;
  import mem_bus_pkg::*;

  logic        clock;
  logic        reset;
  logic        req;
  logic        we;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        ack;
  logic        err;
  logic [31:0] rdata;
  logic        addr_sel_n;
  logic [31:0] bus_ad_out;
  logic        bus_ad_oe;
  logic [31:0] bus_ad_in;
  logic        bus_ale;
  logic        bus_rd_n;
  logic        bus_wr_n;
  logic        bus_ready;

  mem_bus_seq dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .ack        (ack),
    .err        (err),
    .rdata      (rdata),
    .addr_sel_n (addr_sel_n),
    .bus_ad_out (bus_ad_out),
    .bus_ad_oe  (bus_ad_oe),
    .bus_ad_in  (bus_ad_in),
    .bus_ale    (bus_ale),
    .bus_rd_n   (bus_rd_n),
    .bus_wr_n   (bus_wr_n),
    .bus_ready  (bus_ready)
  );

  typedef struct {
    int          ale_cyc;
    int          ack_cyc;
    logic        err;
    logic [31:0] rdata;
    int          ndata;
    logic [31:0] addr_ad;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          ready_at = 0;
  int          dcnt = 0;
  logic [31:0] model_rdata = 32'h0;

  int          m_ale_cyc = 0;
  int          m_ndata = 0;
  logic [31:0] m_addr_ad = 32'h0;
  logic [31:0] m_wr_ad = 32'h0;
  logic        m_prev_ack = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
    chk({tag, "_ack"}, {31'b0, ack}, 32'h0);
    chk({tag, "_err"}, {31'b0, err}, 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_sel_n"}, {31'b0, addr_sel_n}, 32'h0);
    chk({tag, "_ad_out"}, bus_ad_out, 32'h0);
    chk({tag, "_oe"}, {31'b0, bus_ad_oe}, 32'h0);
    chk({tag, "_ale"}, {31'b0, bus_ale}, 32'h0);
    chk({tag, "_rd_n"}, {31'b0, bus_rd_n}, 32'h1);
    chk({tag, "_wr_n"}, {31'b0, bus_wr_n}, 32'h1);
  endtask

  // Target model: ready rises on the ready_at-th strobe cycle (0 = never).
  always @(negedge clock) begin
    if (!bus_rd_n || !bus_wr_n) dcnt = dcnt + 1;
    else dcnt = 0;
    bus_ready = (ready_at != 0) && (dcnt >= ready_at);
  end

  always @(negedge clock) begin
    if (!reset) begin
      m_ndata    = 0;
      m_prev_ack = 1'b0;
    end else begin
      chk("rd_wr_overlap", {31'b0, (!bus_rd_n && !bus_wr_n)}, 32'h0);
      chk("ale_with_strobe", {31'b0, (bus_ale && (!bus_rd_n || !bus_wr_n))}, 32'h0);
      if (m_prev_ack) chk("busy_after_ack", {31'b0, busy}, 32'h0);
      if (bus_ale) begin
        m_ale_cyc = cyc;
        m_addr_ad = bus_ad_out;
        m_ndata   = 0;
        chk("addr_phase_oe_sel", {30'b0, bus_ad_oe, addr_sel_n}, 32'h2);
      end
      if (!bus_wr_n) begin
        m_wr_ad = bus_ad_out;
        chk("write_oe", {31'b0, bus_ad_oe}, 32'h1);
      end
      if (!bus_rd_n) chk("read_oe", {31'b0, bus_ad_oe}, 32'h0);
      if (!bus_rd_n || !bus_wr_n) m_ndata = m_ndata + 1;
      if (ack) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack: got ack=1 expected none (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ale_cycle", m_ale_cyc, e.ale_cyc);
          chk("addr_ad", m_addr_ad, e.addr_ad);
          chk("ack_cycle", cyc, e.ack_cyc);
          chk("data_cycles", m_ndata, e.ndata);
          chk("err", {31'b0, err}, {31'b0, e.err});
          chk("rdata", rdata, e.rdata);
          chk("busy_at_ack", {31'b0, busy}, 32'h1);
          if (e.we) chk("write_ad", m_wr_ad, e.wdata);
        end
        done_cnt = done_cnt + 1;
      end
      m_prev_ack = ack;
    end
  end

  task automatic push_exp(input int c0, input logic w, input logic [23:0] a,
                          input logic [31:0] d, input int rdy, input logic [31:0] din);
    exp_t e;
    logic to;
    int   n;
    to = (rdy == 0) || (rdy > 16);
    n  = to ? 16 : rdy;
    if (!w && !to) model_rdata = din;
    e.ale_cyc = c0 + 1;
    e.ack_cyc = c0 + 2 + n;
    e.err     = to;
    e.rdata   = model_rdata;
    e.ndata   = n;
    e.addr_ad = {8'h00, a};
    e.we      = w;
    e.wdata   = d;
    q.push_back(e);
  endtask

  task automatic wait_done(input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (done_cnt < target) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d acks expected %0d", nm, done_cnt, target);
    end
  endtask

  task automatic xfer(input string nm, input logic w, input logic [23:0] a,
                      input logic [31:0] d, input int rdy, input logic [31:0] din);
    int d0;
    @(negedge clock);
    for (int k = 0; k < 10 && busy; k++) @(negedge clock);
    req = 1'b1; we = w; addr = a; wdata = d; ready_at = rdy; bus_ad_in = din;
    push_exp(cyc, w, a, d, rdy, din);
    d0 = done_cnt;
    @(negedge clock);
    req = 1'b0;
    wait_done(d0 + 1, 40, nm);
  endtask

  initial begin
    int c0;
    int d0;
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; bus_ad_in = '0;
    bus_ready = 1'b0;
    #1 reset = 1'b0;
    #2 chk_reset_vals("por");
    #19 reset = 1'b1;

    xfer("wr_basic",   1'b1, 24'hABCDEF, 32'h12345678, 1,  32'h0);
    xfer("rd_wait3",   1'b0, 24'h000010, 32'h0,        4,  32'hDEADBEEF);
    xfer("rd_timeout", 1'b0, 24'h000020, 32'h0,        0,  32'h0BADF00D);
    xfer("rd_last",    1'b0, 24'h000030, 32'h0,        16, 32'hCAFEF00D);

    // Back-to-back writes with req held; fields change mid-transfer to prove capture.
    @(negedge clock);
    c0 = cyc;
    d0 = done_cnt;
    req = 1'b1; we = 1'b1; addr = 24'h111111; wdata = 32'hAAAA0001; ready_at = 1;
    push_exp(c0,     1'b1, 24'h111111, 32'hAAAA0001, 1, 32'h0);
    push_exp(c0 + 4, 1'b1, 24'h222222, 32'hAAAA0002, 1, 32'h0);
    push_exp(c0 + 8, 1'b1, 24'h333333, 32'hAAAA0003, 1, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      if (k == 1) begin addr = 24'h222222; wdata = 32'hAAAA0002; end
      if (k == 5) begin addr = 24'h333333; wdata = 32'hAAAA0003; end
      if (k == 9) req = 1'b0;
    end
    wait_done(d0 + 3, 40, "b2b");

    // Reset during the data phase of a write: outputs clear at once, no ack follows.
    @(negedge clock);
    d0 = done_cnt;
    req = 1'b1; we = 1'b1; addr = 24'h0F0F0F; wdata = 32'h55AA55AA; ready_at = 0;
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    chk("rst_in_data_wr_n", {31'b0, bus_wr_n}, 32'h0);
    #2 reset = 1'b0;
    model_rdata = 32'h0;
    #1 chk_reset_vals("mid");
    @(negedge clock);
    #2 reset = 1'b1;
    repeat (20) @(negedge clock);
    chk("no_ack_after_reset", done_cnt, d0);

    xfer("wr_after_rst", 1'b1, 24'h00BEEF, 32'h87654321, 1, 32'h0);
    xfer("rd_after_rst", 1'b0, 24'hFEDCBA, 32'h0,        2, 32'h13579BDF);

    repeat (3) @(negedge clock);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
